// File: rtl/seg_bcd_counter_if.sv
// rtl/seg_bcd_counter_if.sv - control inputs and count outputs of seg_bcd_counter
interface seg_bcd_counter_if #(
  parameter int NUM_DIG = 4
);
  logic                   en;
  logic                   up_dn;
  logic                   clr;
  logic                   load;
  logic [4*NUM_DIG-1:0]   load_val;
  logic                   ovf_clr;
  logic [4*NUM_DIG-1:0]   digits;
  logic                   co;
  logic                   ovf_sticky;
  logic                   load_err;

  modport master (
    output en, up_dn, clr, load, load_val, ovf_clr,
    input  digits, co, ovf_sticky, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val, ovf_clr,
    output digits, co, ovf_sticky, load_err
  );
endinterface

// File: rtl/seg_bcd_counter.sv
// rtl/seg_bcd_counter.sv - parametrised multi-digit up/down BCD counter
module seg_bcd_counter #(
  parameter int NUM_DIG  = 4,
  parameter int TOP_MAX  = 9,
  parameter bit SATURATE = 1'b0
) (
  input logic              clk,
  input logic              reset_n,
  seg_bcd_counter_if.slave bus
);
  localparam int W = 4 * NUM_DIG;

  logic [W-1:0] dig_q;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] load_fix;
  logic         term_up;
  logic         term_dn;
  logic         load_bad;
  logic         terminal;
  logic         step;
  logic         ovf_q;
  logic         load_err_q;

  // Next +1 / -1 values and sanitised load value, carry and borrow rippling within the cycle
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    logic [3:0] lv;
    logic [3:0] dmax;
    carry    = 1'b1;
    borrow   = 1'b1;
    load_bad = 1'b0;
    inc_val  = '0;
    dec_val  = '0;
    load_fix = '0;
    d        = '0;
    lv       = '0;
    dmax     = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      d    = dig_q[4*i +: 4];
      lv   = bus.load_val[4*i +: 4];
      dmax = (i == NUM_DIG - 1) ? 4'(TOP_MAX) : 4'd9;
      inc_val[4*i +: 4] = carry  ? ((d == dmax)  ? 4'd0 : d + 4'd1) : d;
      dec_val[4*i +: 4] = borrow ? ((d == 4'd0)  ? dmax : d - 4'd1) : d;
      carry  = carry  & (d == dmax);
      borrow = borrow & (d == 4'd0);
      // An out-of-range load digit is forced to zero and flagged
      if (lv > dmax) begin
        load_bad = 1'b1;
      end else begin
        load_fix[4*i +: 4] = lv;
      end
    end
    term_up = carry;
    term_dn = borrow;
  end

  assign terminal       = bus.up_dn ? term_up : term_dn;
  assign step           = bus.en & ~bus.clr & ~bus.load;
  assign bus.co         = step & terminal & reset_n;
  assign bus.digits     = dig_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.load_err   = load_err_q;

  // Digit register and load error flag: clr beats load beats counting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dig_q      <= '0;
      load_err_q <= 1'b0;
    end else if (bus.clr) begin
      dig_q      <= '0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      dig_q      <= load_fix;
      load_err_q <= load_bad;
    end else begin
      load_err_q <= 1'b0;
      if (bus.en && !(terminal && SATURATE)) begin
        dig_q <= bus.up_dn ? inc_val : dec_val;
      end
    end
  end

  // Sticky overflow: a wrap/saturate event in the same cycle wins over ovf_clr
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (step && terminal) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seg_bcd_counter.sv
// tb/tb_seg_bcd_counter.sv - randomized and directed check of seg_bcd_counter against an integer model
module tb_seg_bcd_counter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_bcd_counter_if #(.NUM_DIG(4)) if0 ();
  seg_bcd_counter_if #(.NUM_DIG(4)) if1 ();
  seg_bcd_counter_if #(.NUM_DIG(4)) if2 ();

  assign if0.en = en;  assign if0.up_dn = up_dn;  assign if0.clr = clr;
  assign if0.load = load;  assign if0.load_val = load_val;  assign if0.ovf_clr = ovf_clr;
  assign if1.en = en;  assign if1.up_dn = up_dn;  assign if1.clr = clr;
  assign if1.load = load;  assign if1.load_val = load_val;  assign if1.ovf_clr = ovf_clr;
  assign if2.en = en;  assign if2.up_dn = up_dn;  assign if2.clr = clr;
  assign if2.load = load;  assign if2.load_val = load_val;  assign if2.ovf_clr = ovf_clr;

  seg_bcd_counter #(.NUM_DIG(4), .TOP_MAX(9), .SATURATE(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  seg_bcd_counter #(.NUM_DIG(4), .TOP_MAX(5), .SATURATE(1'b0)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  seg_bcd_counter #(.NUM_DIG(4), .TOP_MAX(9), .SATURATE(1'b1)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  logic [15:0] dut_dig [3];
  logic        dut_co  [3];
  logic        dut_ovf [3];
  logic        dut_le  [3];
  assign dut_dig[0] = if0.digits;  assign dut_co[0] = if0.co;  assign dut_ovf[0] = if0.ovf_sticky;  assign dut_le[0] = if0.load_err;
  assign dut_dig[1] = if1.digits;  assign dut_co[1] = if1.co;  assign dut_ovf[1] = if1.ovf_sticky;  assign dut_le[1] = if1.load_err;
  assign dut_dig[2] = if2.digits;  assign dut_co[2] = if2.co;  assign dut_ovf[2] = if2.ovf_sticky;  assign dut_le[2] = if2.load_err;

  // Model: each instance is an integer count modulo (TOP_MAX+1)*1000
  int topm [3] = '{9, 5, 9};
  bit sat  [3] = '{1'b0, 1'b0, 1'b1};
  int cnt  [3] = '{0, 0, 0};
  bit ovf_m[3] = '{1'b0, 1'b0, 1'b0};
  bit le_m [3] = '{1'b0, 1'b0, 1'b0};
  bit chk_en = 1'b1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit exp_co(input int k);
    int m;
    m = (topm[k] + 1) * 1000;
    return reset_n && en && !clr && !load && (up_dn ? (cnt[k] == m - 1) : (cnt[k] == 0));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int m;
      int lv;
      int pw;
      int d;
      int mx;
      bit bad;
      bit evt;
      m = (topm[k] + 1) * 1000;
      evt = 1'b0;
      if (!reset_n) begin
        cnt[k] = 0; ovf_m[k] = 1'b0; le_m[k] = 1'b0;
      end else begin
        if (clr) begin
          cnt[k] = 0; le_m[k] = 1'b0;
        end else if (load) begin
          lv = 0; pw = 1; bad = 1'b0;
          for (int i = 0; i < 4; i++) begin
            d  = int'((load_val >> (4 * i)) & 16'hF);
            mx = (i == 3) ? topm[k] : 9;
            if (d > mx) bad = 1'b1;
            else lv += d * pw;
            pw *= 10;
          end
          cnt[k] = lv; le_m[k] = bad;
        end else begin
          le_m[k] = 1'b0;
          if (en && up_dn) begin
            if (cnt[k] == m - 1) begin evt = 1'b1; if (!sat[k]) cnt[k] = 0; end
            else cnt[k] = cnt[k] + 1;
          end else if (en) begin
            if (cnt[k] == 0) begin evt = 1'b1; if (!sat[k]) cnt[k] = m - 1; end
            else cnt[k] = cnt[k] - 1;
          end
        end
        if (evt) ovf_m[k] = 1'b1;
        else if (ovf_clr) ovf_m[k] = 1'b0;
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input bit u, input bit c, input bit l, input logic [15:0] lv, input bit oc);
    en = e; up_dn = u; clr = c; load = l; load_val = lv; ovf_clr = oc;
  endtask

  initial begin
    int co_cnt;
    int r;

    // Per-cycle comparison of all three instances against the model
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int k = 0; k < 3; k++) begin
            lit($sformatf("cyc u%0d digits", k), dut_dig[k], to_bcd(cnt[k]));
            lit($sformatf("cyc u%0d co", k), 16'(dut_co[k]), 16'(exp_co(k)));
            lit($sformatf("cyc u%0d ovf_sticky", k), 16'(dut_ovf[k]), 16'(ovf_m[k]));
            lit($sformatf("cyc u%0d load_err", k), 16'(dut_le[k]), 16'(le_m[k]));
          end
        end
      end
    join_none

    // Reset state
    drive(1, 1, 0, 0, 16'h0000, 0);
    cyc(); cyc();
    lit("reset digits", if0.digits, 16'h0000);
    lit("reset ovf", 16'(if0.ovf_sticky), 16'h0);
    lit("reset load_err", 16'(if0.load_err), 16'h0);
    lit("reset co", 16'(if0.co), 16'h0);

    // Full up-count sweep
    reset_n = 1'b1;
    co_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 9999) lit("sweep digits at 9999", if0.digits, 16'h9999);
      if (if0.co) co_cnt++;
      cyc();
    end
    lit("sweep co count", 16'(co_cnt), 16'd1);
    lit("sweep wrapped digits", if0.digits, 16'h0000);
    lit("sweep ovf", 16'(if0.ovf_sticky), 16'h1);
    lit("sat sweep holds", if2.digits, 16'h9999);

    // Carry/borrow across digits and down wrap
    drive(0, 1, 0, 1, 16'h0199, 0); cyc();
    drive(1, 1, 0, 0, 16'h0000, 0); cyc();
    lit("up 0199", if0.digits, 16'h0200);
    drive(1, 0, 0, 0, 16'h0000, 0); cyc();
    lit("down 0200", if0.digits, 16'h0199);
    drive(0, 0, 1, 0, 16'h0000, 0); cyc();
    drive(1, 0, 0, 0, 16'h0000, 0); #1;
    lit("down wrap co", 16'(if0.co), 16'h1);
    cyc();
    lit("down wrap digits", if0.digits, 16'h9999);

    // TOP_MAX=5 instance
    drive(0, 1, 0, 1, 16'h5999, 0); cyc();
    drive(1, 1, 0, 0, 16'h0000, 0); #1;
    lit("top5 co", 16'(if1.co), 16'h1);
    cyc();
    lit("top5 wrap", if1.digits, 16'h0000);
    drive(0, 1, 0, 1, 16'h6000, 0); cyc();
    lit("top5 bad load digits", if1.digits, 16'h0000);
    lit("top5 load_err", 16'(if1.load_err), 16'h1);
    lit("top9 load 6000", if0.digits, 16'h6000);
    drive(0, 1, 0, 0, 16'h0000, 0); cyc();
    lit("load_err one cycle", 16'(if1.load_err), 16'h0);

    // Saturating instance
    drive(0, 1, 0, 1, 16'h9999, 0); cyc();
    drive(1, 1, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      lit("sat up co", 16'(if2.co), 16'h1);
      cyc();
      lit("sat up digits", if2.digits, 16'h9999);
    end
    lit("sat ovf", 16'(if2.ovf_sticky), 16'h1);
    drive(0, 1, 0, 1, 16'h0000, 0); cyc();
    drive(1, 0, 0, 0, 16'h0000, 0); cyc();
    lit("sat down digits", if2.digits, 16'h0000);

    // Priorities and ovf_clr interaction
    drive(0, 1, 0, 1, 16'h1234, 0); cyc();
    drive(1, 1, 1, 1, 16'h5555, 0); #1;
    lit("clr+load+en co", 16'(if0.co), 16'h0);
    cyc();
    lit("clr+load+en digits", if0.digits, 16'h0000);
    drive(1, 1, 0, 1, 16'h0042, 0); cyc();
    lit("load beats en", if0.digits, 16'h0042);
    drive(0, 1, 0, 0, 16'h0000, 1); cyc();
    lit("ovf_clr clears", 16'(if0.ovf_sticky), 16'h0);
    drive(0, 1, 0, 1, 16'h9999, 0); cyc();
    drive(1, 1, 0, 0, 16'h0000, 1); cyc();
    lit("ovf set beats clr", 16'(if0.ovf_sticky), 16'h1);

    // Reset mid-count overrides load
    drive(0, 1, 0, 1, 16'h4321, 0); cyc();
    drive(1, 1, 0, 0, 16'h0000, 0); cyc();
    reset_n = 1'b0;
    drive(1, 1, 0, 1, 16'hAAAA, 0); cyc();
    lit("rst digits", if0.digits, 16'h0000);
    lit("rst load_err", 16'(if0.load_err), 16'h0);
    lit("rst ovf", 16'(if0.ovf_sticky), 16'h0);
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      en      = ($urandom_range(0, 3) != 0);
      up_dn   = 1'($urandom);
      clr     = ($urandom_range(0, 31) == 0);
      load    = ($urandom_range(0, 15) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 3);
      case (r)
        0: load_val = 16'($urandom);
        1: load_val = 16'h9999;
        2: load_val = 16'h5999;
        default: load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      cyc();
    end

    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
